// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) reducer: FSM state encoding,
// standard field polynomials, and the STEP legality check.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low coefficients only; the x^m term is implicit.
    localparam logic [7:0]  GF8_POLY  = 8'h1B;         // x^8+x^4+x^3+x+1
    localparam logic [31:0] GF32_POLY = 32'h0000_008D; // x^32+x^7+x^3+x^2+1

    // STEP must be a positive divisor of the field degree.
    function automatic bit step_legal(input int data_width, input int step);
        return (step > 0) && (step <= data_width) && ((data_width % step) == 0);
    endfunction

endpackage

// File: rtl/gf_reduce_step.sv
// Combinational fold of STEP product bits, from top_idx downward, against
// the field polynomial. Each set bit j (j >= m) is cleared by XORing in
// {1,poly} << (j-m); bits are handled top-first so lower folds see the
// effect of upper ones.
module gf_reduce_step
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4,
    parameter int IW         = $clog2(2 * DATA_WIDTH)
) (
    input  logic [2*DATA_WIDTH-1:0] r_in,
    input  logic [DATA_WIDTH-1:0]   poly,
    input  logic [IW-1:0]           top_idx,
    output logic [2*DATA_WIDTH-1:0] r_out
);

    logic [2*DATA_WIDTH-1:0] poly_full;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [IW-1:0]           bit_idx;

    assign poly_full = {{(DATA_WIDTH-1){1'b0}}, 1'b1, poly};

    // Walk STEP bits top-down, cancelling each set bit with a shifted polynomial
    always_comb begin
        acc     = r_in;
        bit_idx = top_idx;
        for (int i = 0; i < STEP; i++) begin
            bit_idx = top_idx - IW'(i);
            if (acc[bit_idx]) begin
                acc = acc ^ (poly_full << (bit_idx - IW'(DATA_WIDTH)));
            end
        end
    end

    assign r_out = acc;

endmodule

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^m) reducer: takes a 2m-bit carry-less product and returns
// the m-bit residue modulo a runtime polynomial, folding STEP bits per cycle.
// carry_option=1 bypasses reduction and returns the low m product bits.
// Optional: GF_REDUCE_EARLY_EXIT_EN finishes as soon as the upper half of
// the working register is clear (same results, shorter latency).
module gf_reduce_seq
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    carry_option,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] prod,
    input  logic [DATA_WIDTH-1:0]   poly,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out
);

    localparam int NCHUNK = DATA_WIDTH / STEP;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = $clog2(2 * DATA_WIDTH);

    if (!step_legal(DATA_WIDTH, STEP)) begin : g_step_check
        $error("gf_reduce_seq: STEP must be a positive divisor of DATA_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0]   poly_q, poly_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [IW-1:0]           top_idx;
    logic [2*DATA_WIDTH-1:0] r_fold;

    // Current top bit: chunk cnt covers bits [m+cnt*STEP-1 -: STEP]
    assign top_idx = IW'(DATA_WIDTH - 1 + int'(cnt_q) * STEP);

    gf_reduce_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .STEP      (STEP),
        .IW        (IW)
    ) u_step (
        .r_in   (r_q),
        .poly   (poly_q),
        .top_idx(top_idx),
        .r_out  (r_fold)
    );

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        poly_d    = poly_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_d    = prod;
                    poly_d = poly;
                    mode_d = carry_option;
                    cnt_d  = CW'(NCHUNK);
                    if (carry_option) begin
                        state_d = DONE;
                    end else begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
                        // Already below x^m: nothing to fold
                        state_d = (prod[2*DATA_WIDTH-1:DATA_WIDTH] == '0) ? DONE : RUN;
`else
                        state_d = RUN;
`endif
                    end
                end
            end
            RUN: begin
                r_d   = r_fold;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
`ifdef GF_REDUCE_EARLY_EXIT_EN
                else if (r_fold[2*DATA_WIDTH-1:DATA_WIDTH] == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                out       = r_q[DATA_WIDTH-1:0];
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            poly_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            poly_q  <= poly_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // A finished GF reduction must leave nothing at or above x^m
    a_upper_clear: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DONE && !mode_q) |-> (r_q[2*DATA_WIDTH-1:DATA_WIDTH] == '0));

endmodule
